f_job_scheduler: RTL and testbench

F_JOB_SCHEDULER -- requirements
Module: f_job_scheduler

---
 rtl/f_job_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_f_job_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_job_scheduler.sv
// f_job_scheduler: round-robin F job issue with an in-order tag FIFO and H reload.
// Define F_SCHED_WDOG_EN to build the result watchdog (err_wdog).
module f_job_scheduler #(
    parameter int J           = 14,
    parameter int N_REQ       = 4,
    parameter int TAG_DEPTH   = 16,
    parameter int WDOG_CYCLES = 1024,
    parameter int AWIDTH      = $clog2(2) + 1,
    localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*J*AWIDTH-1:0] req_x,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      h_load_valid,
    input  logic [J*64-1:0]           h_load_data,
    output logic                      h_load_ready,
    output logic [J*64-1:0]           dp_H,
    output logic                      dp_H_tvalid,
    output logic [AWIDTH-1:0]         dp_x,
    output logic                      dp_x_tvalid,
    input  logic [63:0]               dp_F_value,
    input  logic                      dp_F_tvalid,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [63:0]               rsp_data,
    output logic                      err_unexpected,
    output logic                      err_wdog
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam int XW = J * AWIDTH;
    localparam int EW = (J > 1) ? $clog2(J) : 1;

    if (WDOG_CYCLES < 1 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_param_chk
        $error("f_job_scheduler: illegal WDOG_CYCLES or TAG_DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HLOAD
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [XW-1:0]   x_q, x_d;
    logic [EW-1:0]   cnt_q, cnt_d;
    logic [J*64-1:0] h_q, h_d;

    logic [IDW-1:0]  tag_mem_q [TAG_DEPTH];
    logic [PW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   occ_q;

    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [63:0]     rsp_data_q;
    logic            err_unexp_q;

    logic            found;
    logic [IDW-1:0]  gnt_id;
    logic            push, pop, full, empty;

    assign full  = (occ_q == CW'(TAG_DEPTH));
    assign empty = (occ_q == '0);
    assign pop   = dp_F_tvalid && !empty;

    // First requesting index at or after rr_q, wrapping.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[(int'(rr_q) + i) % N_REQ]) begin
                found  = 1'b1;
                gnt_id = IDW'((int'(rr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        x_d          = x_q;
        cnt_d        = cnt_q;
        h_d          = h_q;
        push         = 1'b0;
        req_ready    = '0;
        dp_x_tvalid  = 1'b0;
        dp_x         = '0;
        dp_H_tvalid  = 1'b0;
        h_load_ready = 1'b0;
        dp_H         = h_q;
        unique case (state_q)
            IDLE: begin
                if (h_load_valid) begin
                    state_d = DRAIN;
                end else if (found && !full && !rst) begin
                    push              = 1'b1;
                    req_ready[gnt_id] = 1'b1;
                    x_d               = req_x[int'(gnt_id)*XW +: XW];
                    rr_d              = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
                    cnt_d             = '0;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                dp_x_tvalid = 1'b1;
                dp_x        = x_q[int'(cnt_q)*AWIDTH +: AWIDTH];
                if (cnt_q == EW'(J - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_d = HLOAD;
                end
            end
            HLOAD: begin
                dp_H_tvalid  = 1'b1;
                h_load_ready = 1'b1;
                dp_H         = h_load_data;
                h_d          = h_load_data;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wp_q] <= gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            occ_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            err_unexp_q <= 1'b0;
        end else begin
            if (push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q       <= rp_q + 1'b1;
                rsp_id_q   <= tag_mem_q[rp_q];
                rsp_data_q <= dp_F_value;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
            rsp_valid_q <= pop;
            if (dp_F_tvalid && empty) begin
                err_unexp_q <= 1'b1;
            end
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_data       = rsp_data_q;
    assign err_unexpected = err_unexp_q;

`ifdef F_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_wdog_q;

    // Counts stalled cycles with work in flight; saturates at the limit.
    always_comb begin
        wdog_d = wdog_q;
        if (pop || empty) begin
            wdog_d = '0;
        end else if (wdog_q != WW'(WDOG_CYCLES)) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q     <= '0;
            err_wdog_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (wdog_d == WW'(WDOG_CYCLES)) begin
                err_wdog_q <= 1'b1;
            end
        end
    end

    assign err_wdog = err_wdog_q;
`else
    assign err_wdog = 1'b0;
`endif

endmodule

// File: tb/tb_f_job_scheduler.sv
// tb_f_job_scheduler: directed checks of grant order, issue bursts,
// tag FIFO ordering/full, H reload, error flags and reset.
`timescale 1ns/1ps
module tb_f_job_scheduler;

    localparam int J     = 14;
    localparam int N_REQ = 4;
    localparam int AW    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*J*AW-1:0]  req_x;
    logic [N_REQ-1:0]       req_ready;
    logic                   h_load_valid;
    logic [J*64-1:0]        h_load_data;
    logic                   h_load_ready;
    logic [J*64-1:0]        dp_H;
    logic                   dp_H_tvalid;
    logic [AW-1:0]          dp_x;
    logic                   dp_x_tvalid;
    logic [63:0]            dp_F_value;
    logic                   dp_F_tvalid;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [63:0]            rsp_data;
    logic                   err_unexpected;
    logic                   err_wdog;

    int checks   = 0;
    int failures = 0;

    logic [J*64-1:0] hpat;

    f_job_scheduler #(
        .J(J), .N_REQ(N_REQ), .TAG_DEPTH(16), .WDOG_CYCLES(32), .AWIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .h_load_valid(h_load_valid), .h_load_data(h_load_data),
        .h_load_ready(h_load_ready),
        .dp_H(dp_H), .dp_H_tvalid(dp_H_tvalid),
        .dp_x(dp_x), .dp_x_tvalid(dp_x_tvalid),
        .dp_F_value(dp_F_value), .dp_F_tvalid(dp_F_tvalid),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .err_unexpected(err_unexpected), .err_wdog(err_wdog)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    function automatic logic [AW-1:0] elem(input int r, input int e);
        return AW'((r + e) % 4);
    endfunction

    task automatic burst(input int r, input bit allone, output int ok);
        logic [AW-1:0] ex;
        ok = 0;
        for (int e = 0; e < J; e++) begin
            smp;
            ex = allone ? AW'(1) : elem(r, e);
            if (dp_x_tvalid === 1'b1 && dp_x === ex) ok++;
            tick;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int ok, ng, bad, lat;
        logic [N_REQ-1:0] first;
        rst = 1'b1; req_valid = '0; req_x = '0;
        h_load_valid = 1'b0; h_load_data = '0;
        dp_F_value = '0; dp_F_tvalid = 1'b0;
        for (int i = 0; i < J; i++) hpat[i*64 +: 64] = 64'h3ff0_0000_0000_0000 + 64'(i);
        tick; tick;
        smp;
        chk("rst_ready", req_ready, 0);
        chk("rst_xv", dp_x_tvalid, 0);
        chk("rst_x", dp_x, 0);
        chk("rst_hv", dp_H_tvalid, 0);
        chk("rst_hr", h_load_ready, 0);
        chk("rst_h", dp_H[63:0], 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_rid", rsp_id, 0);
        chk("rst_rdata", rsp_data, 0);
        chk("rst_eu", err_unexpected, 0);
        chk("rst_ew", err_wdog, 0);
        tick;
        rst = 1'b0;

        // single job
        for (int e = 0; e < J; e++) req_x[e*AW +: AW] = 2'd1;
        req_valid = 4'b0001;
        smp; chk("sj_ready", req_ready, 4'b0001);
        tick; req_valid = '0;
        burst(0, 1'b1, ok); chk("sj_beats", ok, J);
        smp; chk("sj_gap", dp_x_tvalid, 0);
        tick; dp_F_tvalid = 1'b1; dp_F_value = 64'h4000_0000_0000_0000;
        tick; dp_F_tvalid = 1'b0;
        smp;
        chk("sj_rv", rsp_valid, 1);
        chk("sj_rid", rsp_id, 0);
        chk("sj_rdata", rsp_data, 64'h4000_0000_0000_0000);
        tick; smp; chk("sj_rv_pulse", rsp_valid, 0);

        // result with nothing in flight
        tick; dp_F_tvalid = 1'b1; dp_F_value = 64'hdead;
        tick; dp_F_tvalid = 1'b0;
        smp;
        chk("unx_err", err_unexpected, 1);
        chk("unx_rv", rsp_valid, 0);
        tick;

        // round robin from reset
        do_reset;
        for (int r = 0; r < N_REQ; r++)
            for (int e = 0; e < J; e++) req_x[(r*J+e)*AW +: AW] = elem(r, e);
        req_valid = 4'hf;
        for (int k = 0; k < 5; k++) begin
            smp;
            chk($sformatf("rr_gnt%0d", k), req_ready, 64'(1 << (k % 4)));
            chk($sformatf("rr_idle%0d", k), dp_x_tvalid, 0);
            tick;
            if (k == 4) req_valid = '0;
            burst(k % 4, 1'b0, ok);
            chk($sformatf("rr_beats%0d", k), ok, J);
        end
        for (int k = 0; k < 5; k++) begin
            dp_F_tvalid = 1'b1; dp_F_value = 64'(100 + k);
            tick; dp_F_tvalid = 1'b0;
            smp;
            chk($sformatf("rr_rid%0d", k), rsp_id, k % 4);
            chk($sformatf("rr_rdata%0d", k), rsp_data, 64'(100 + k));
            tick;
        end
        dp_F_tvalid = 1'b1;
        tick; dp_F_tvalid = 1'b0;
        smp; chk("rr_unx", err_unexpected, 1);
        tick;

        // fill the tag FIFO
        req_valid = 4'hf; ng = 0; first = '0;
        for (int c = 0; c < 280; c++) begin
            smp;
            if (req_ready != '0) begin
                if (ng == 0) first = req_ready;
                ng++;
            end
            tick;
        end
        chk("full_grants", ng, 16);
        chk("full_first", first, 4'b0010);
        smp; chk("full_hold", req_ready, 0);
        tick; dp_F_tvalid = 1'b1; dp_F_value = 64'h1234;
        smp; chk("full_popcyc", req_ready, 0);
        tick; dp_F_tvalid = 1'b0;
        smp;
        chk("full_rv", rsp_valid, 1);
        chk("full_rid", rsp_id, 1);
        chk("full_rdata", rsp_data, 64'h1234);
        chk("full_g17", req_ready, 4'b0010);
        tick; req_valid = '0;
        smp; chk("mid_busy", dp_x_tvalid, 1);

        // reset in the middle of a burst
        tick; rst = 1'b1;
        tick;
        smp;
        chk("mrst_xv", dp_x_tvalid, 0);
        chk("mrst_eu", err_unexpected, 0);
        chk("mrst_ew", err_wdog, 0);
        chk("mrst_rv", rsp_valid, 0);
        tick; rst = 1'b0;
        dp_F_tvalid = 1'b1;
        tick; dp_F_tvalid = 1'b0;
        smp;
        chk("mrst_empty_rv", rsp_valid, 0);
        chk("mrst_empty_eu", err_unexpected, 1);
        tick;

        // H load behind 3 outstanding jobs
        do_reset;
        req_valid = 4'hf;
        for (int k = 0; k < 3; k++) begin
            smp;
            chk($sformatf("hl_gnt%0d", k), req_ready, 64'(1 << k));
            tick;
            if (k == 2) begin
                h_load_valid = 1'b1;
                h_load_data  = hpat;
            end
            burst(k, 1'b0, ok);
            chk($sformatf("hl_beats%0d", k), ok, J);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            smp;
            if (req_ready != '0 || dp_H_tvalid) bad++;
            tick;
        end
        for (int k = 0; k < 3; k++) begin
            dp_F_tvalid = 1'b1; dp_F_value = 64'(k);
            tick; dp_F_tvalid = 1'b0;
            smp;
            chk($sformatf("hl_rid%0d", k), rsp_id, k);
            if (req_ready != '0 || dp_H_tvalid) bad++;
            tick;
        end
        chk("hl_blocked", bad, 0);
        lat = -1;
        for (int i = 0; i < 5; i++) begin
            smp;
            if (dp_H_tvalid) begin
                lat = i;
                chk("hl_ready", h_load_ready, 1);
                chk("hl_data", dp_H == hpat, 1);
                chk("hl_data_top", dp_H[J*64-1 -: 64], 64'h3ff0_0000_0000_000d);
                tick;
                break;
            end
            tick;
        end
        chk("hl_lat", lat, 0);
        req_valid = '0; h_load_valid = 1'b0; h_load_data = '0;
        smp;
        chk("hl_pulse", dp_H_tvalid, 0);
        chk("hl_hold", dp_H == hpat, 1);
        chk("hl_nogrant", req_ready, 0);
        tick;

        // watchdog
        do_reset;
        req_valid = 4'b0001;
        smp; chk("wd_gnt", req_ready, 4'b0001);
        tick; req_valid = '0;
        repeat (31) tick;
        smp; chk("wd_31", err_wdog, 0);
        tick;
        smp;
`ifdef F_SCHED_WDOG_EN
        chk("wd_32", err_wdog, 1);
`else
        chk("wd_32", err_wdog, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
